// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file and its clear sweeper.
package regfile_pkg;

    localparam int RF_ADDRESS_WIDTH_DEFAULT = 5;
    localparam int RF_DATA_WIDTH_DEFAULT    = 32;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'b00,
        CLR_SWEEP = 2'b01,
        CLR_DONE  = 2'b10
    } clr_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks indices 1..2**ADDRESS_WIDTH-1 one per cycle, then pulses done.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_req_i,
    output clr_state_e               state_o,
    output logic [ADDRESS_WIDTH-1:0] clr_idx_o,
    output logic                     clear_busy_o,
    output logic                     clear_done_o
);

    localparam logic [ADDRESS_WIDTH-1:0] L_FIRST_IDX = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH-1:0] L_LAST_IDX  = {ADDRESS_WIDTH{1'b1}};

    clr_state_e               r_state;
    clr_state_e               w_state_next;
    logic [ADDRESS_WIDTH-1:0] r_idx;
    logic [ADDRESS_WIDTH-1:0] w_idx_next;
    logic                     r_busy;
    logic                     r_done;
    logic                     w_busy_next;
    logic                     w_done_next;

    // State, sweep index and status flops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= CLR_IDLE;
            r_idx   <= L_FIRST_IDX;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state and sweep index; requests outside IDLE are dropped
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            CLR_IDLE: begin
                w_idx_next = L_FIRST_IDX;
                if (clear_req_i) begin
                    w_state_next = CLR_SWEEP;
                end else begin
                    w_state_next = CLR_IDLE;
                end
            end
            CLR_SWEEP: begin
                if (r_idx == L_LAST_IDX) begin
                    w_state_next = CLR_DONE;
                    w_idx_next   = L_FIRST_IDX;
                end else begin
                    w_state_next = CLR_SWEEP;
                    w_idx_next   = r_idx + L_FIRST_IDX;
                end
            end
            CLR_DONE: begin
                w_state_next = CLR_IDLE;
                w_idx_next   = L_FIRST_IDX;
            end
            default: begin
                w_state_next = CLR_IDLE;
                w_idx_next   = L_FIRST_IDX;
            end
        endcase
    end

    // Status decoded from the next state so busy/done come straight off flops
    always_comb begin
        w_busy_next = 1'b0;
        w_done_next = 1'b0;
        case (w_state_next)
            CLR_SWEEP: begin
                w_busy_next = 1'b1;
                w_done_next = 1'b0;
            end
            CLR_DONE: begin
                w_busy_next = 1'b1;
                w_done_next = 1'b1;
            end
            default: begin
                w_busy_next = 1'b0;
                w_done_next = 1'b0;
            end
        endcase
    end

    assign state_o      = r_state;
    assign clr_idx_o    = r_idx;
    assign clear_busy_o = r_busy;
    assign clear_done_o = r_done;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with trigger input register, debug mirror and clear sweep.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data / trigger to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH_DEFAULT,
    parameter int DATA_WIDTH    = RF_DATA_WIDTH_DEFAULT,
    parameter int NUM_READ      = 2,
    parameter int NUM_WRITE     = 2,
    parameter int INPUT_REG     = 19,
    parameter int DEBUG_REG     = 10
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NUM_WRITE-1:0]                    we_i,
    input  logic [NUM_WRITE-1:0][ADDRESS_WIDTH-1:0] waddr_i,
    input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0]    wdata_i,
    input  logic [NUM_READ-1:0][ADDRESS_WIDTH-1:0]  raddr_i,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0]     rdata_o,
    input  logic                                    trigger_i,
    output logic [DATA_WIDTH-1:0]                   a0_o,
    input  logic                                    clear_req_i,
    output logic                                    clear_busy_o,
    output logic                                    clear_done_o
);

    localparam int                       NUM_REGS    = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] L_ZERO_IDX  = {ADDRESS_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]    L_ZERO_DATA = {DATA_WIDTH{1'b0}};
`ifdef REGFILE_MP_BYPASS_EN
    localparam logic [ADDRESS_WIDTH-1:0] L_INPUT_IDX = ADDRESS_WIDTH'(INPUT_REG);
`endif

    logic [DATA_WIDTH-1:0]    r_rf [NUM_REGS];
    clr_state_e               w_state;
    logic [ADDRESS_WIDTH-1:0] w_clr_idx;
    logic                     w_idle;
    logic [DATA_WIDTH-1:0]    w_trigger_ext;

    regfile_clear_fsm #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_clear_fsm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_req_i  (clear_req_i),
        .state_o      (w_state),
        .clr_idx_o    (w_clr_idx),
        .clear_busy_o (clear_busy_o),
        .clear_done_o (clear_done_o)
    );

    assign w_idle        = (w_state == CLR_IDLE);
    assign w_trigger_ext = {{(DATA_WIDTH-1){1'b0}}, trigger_i};

    // Storage: later ports overwrite earlier ones, and any write beats the trigger load
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_rf[i] <= L_ZERO_DATA;
            end
        end else if (w_idle) begin
            r_rf[INPUT_REG] <= w_trigger_ext;
            for (int p = 0; p < NUM_WRITE; p++) begin
                if (we_i[p] && (waddr_i[p] != L_ZERO_IDX)) begin
                    r_rf[waddr_i[p]] <= wdata_i[p];
                end
            end
        end else if (w_state == CLR_SWEEP) begin
            r_rf[w_clr_idx] <= L_ZERO_DATA;
        end
    end

    // Combinational read ports; index 0 is hardwired to zero
    always_comb begin
        rdata_o = {(NUM_READ*DATA_WIDTH){1'b0}};
        for (int r = 0; r < NUM_READ; r++) begin
            if (raddr_i[r] == L_ZERO_IDX) begin
                rdata_o[r] = L_ZERO_DATA;
            end else begin
                rdata_o[r] = r_rf[raddr_i[r]];
`ifdef REGFILE_MP_BYPASS_EN
                rdata_o[r] = (w_idle && (raddr_i[r] == L_INPUT_IDX)) ? w_trigger_ext : rdata_o[r];
                for (int p = 0; p < NUM_WRITE; p++) begin
                    rdata_o[r] = (w_idle && we_i[p] && (waddr_i[p] == raddr_i[r])) ?
                                 wdata_i[p] : rdata_o[r];
                end
`endif
            end
        end
    end

    assign a0_o = r_rf[DEBUG_REG];

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic against a reference model.
module tb_regfile_mp;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic [1:0]       we;
    logic [1:0][4:0]  waddr;
    logic [1:0][31:0] wdata;
    logic [1:0][4:0]  raddr;
    logic [1:0][31:0] rdata;
    logic             trigger;
    logic [31:0]      a0;
    logic             clear_req;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_rf [32];
    int          m_left;

    regfile_mp dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .we_i         (we),
        .waddr_i      (waddr),
        .wdata_i      (wdata),
        .raddr_i      (raddr),
        .rdata_o      (rdata),
        .trigger_i    (trigger),
        .a0_o         (a0),
        .clear_req_i  (clear_req),
        .clear_busy_o (busy),
        .clear_done_o (done)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_left = 0;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        logic [31:0] v;
        if (a == 5'd0) return 32'd0;
        v = m_rf[a];
`ifdef REGFILE_MP_BYPASS_EN
        if (m_left == 0) begin
            if (a == 5'd19) v = {31'd0, trigger};
            for (int p = 0; p < 2; p++) if (we[p] && waddr[p] == a) v = wdata[p];
        end
`endif
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        #1;
        check("rdata0", rdata[0], exp_read(raddr[0]));
        check("rdata1", rdata[1], exp_read(raddr[1]));
        check("a0", a0, m_rf[10]);
        check("busy", {31'd0, busy}, (m_left > 0) ? 32'd1 : 32'd0);
        check("done", {31'd0, done}, (m_left == 1) ? 32'd1 : 32'd0);
    endtask

    // m_left counts the remaining busy cycles: 32..2 clear index 33-m_left, 1 is the done cycle
    task automatic model_update();
        if (!rst_ni) begin
            model_reset();
        end else if (m_left == 0) begin
            m_rf[19] = {31'd0, trigger};
            for (int p = 0; p < 2; p++) if (we[p] && waddr[p] != 5'd0) m_rf[waddr[p]] = wdata[p];
            if (clear_req) m_left = 32;
        end else begin
            if (m_left >= 2) m_rf[33 - m_left] = 32'd0;
            m_left--;
        end
    endtask

    task automatic cycle();
        check_outputs();
        model_update();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic quiet();
        we = 2'b00;
        clear_req = 1'b0;
        trigger = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i++) begin
            raddr[0] = 5'(i);
            raddr[1] = 5'(31 - i);
            cycle();
        end
    endtask

    task automatic fill_all();
        trigger = 1'b1;
        for (int i = 1; i < 32; i++) begin
            we = (i % 2 == 0) ? 2'b10 : 2'b01;
            waddr[i % 2] = 5'(i);
            wdata[i % 2] = $urandom | 32'h1;
            raddr[0] = 5'(i);
            raddr[1] = 5'($urandom_range(0, 31));
            cycle();
        end
        we = 2'b00;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        quiet();
        waddr = '{5'd0, 5'd0};
        wdata = '{32'd0, 32'd0};
        raddr = '{5'd0, 5'd0};
        model_reset();

        // Reset state: everything reads zero
        read_all();
        rst_ni = 1'b1;

        // Same-index write on both ports: port 1 wins
        we = 2'b11; waddr[0] = 5'd5; waddr[1] = 5'd5;
        wdata[0] = 32'hDEADBEEF; wdata[1] = 32'h12345678;
        raddr[0] = 5'd5; raddr[1] = 5'd0;
        cycle();
        we = 2'b00;
        #1 check("x5_port1_wins", rdata[0], 32'h12345678);
        cycle();

        // Writes to x0 are discarded
        we = 2'b01; waddr[0] = 5'd0; wdata[0] = 32'hFFFFFFFF; raddr[0] = 5'd0;
        cycle();
        we = 2'b00;
        #1 check("x0_reads_zero", rdata[0], 32'd0);
        cycle();

        // Trigger loads x19, and a write to x19 beats the trigger
        trigger = 1'b1; raddr[0] = 5'd19;
        cycle();
        #1 check("x19_trigger", rdata[0], 32'h1);
        cycle();
        we = 2'b01; waddr[0] = 5'd19; wdata[0] = 32'hAA;
        cycle();
        we = 2'b00; trigger = 1'b0;
        cycle();

        // Debug mirror of x10; read in the write cycle depends on bypass build
        we = 2'b01; waddr[0] = 5'd10; wdata[0] = 32'h55; raddr[0] = 5'd10;
        cycle();
        we = 2'b00;
        #1 check("a0_mirror", a0, 32'h55);
        cycle();

        // Full sweep with writes and requests during the sweep being ignored
        fill_all();
        clear_req = 1'b1;
        cycle();
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            we = (k < 30) ? 2'($urandom_range(0, 3)) : 2'b00;
            waddr[0] = 5'($urandom_range(0, 31)); waddr[1] = 5'($urandom_range(0, 31));
            wdata[0] = $urandom; wdata[1] = $urandom;
            raddr[0] = 5'($urandom_range(0, 31)); raddr[1] = 5'($urandom_range(0, 31));
            clear_req = (k < 30) ? 1'($urandom_range(0, 1)) : 1'b0;
            trigger = 1'b0;
            cycle();
        end
        check("sweep_busy_cycles", busy_cnt, 32);
        check("sweep_done_pulses", done_cnt, 1);
        quiet();
        read_all();

        // Reset in the middle of a sweep, just as index 15 is due
        fill_all();
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        repeat (14) cycle();
        rst_ni = 1'b0;
        model_reset();
        quiet();
        read_all();
        rst_ni = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) done_cnt++;
            raddr[0] = 5'($urandom_range(0, 31)); raddr[1] = 5'($urandom_range(0, 31));
            cycle();
        end
        check("no_done_after_abort", done_cnt, 0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            we = 2'($urandom_range(0, 3));
            waddr[0] = 5'($urandom_range(0, 31)); waddr[1] = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) waddr[1] = waddr[0];
            wdata[0] = $urandom; wdata[1] = $urandom;
            raddr[0] = 5'($urandom_range(0, 31)); raddr[1] = 5'($urandom_range(0, 31));
            trigger = 1'($urandom_range(0, 1));
            clear_req = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
